// File: rtl/sync_filter.sv
// sync_filter: multi-channel input conditioner for asynchronous pad inputs.
// Each channel runs through a SYNC_STAGES-deep synchronizer, then a glitch
// filter that only moves the output after FILT_CNT consecutive ce-qualified
// samples differ from the current output level.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high; overrides everything else
//   ce      - filter sample enable; the synchronizer ignores it
//   din     - raw asynchronous inputs, one bit per channel
//   dout    - filtered level per channel (registered)
//   rise    - one-clock pulse when dout[i] goes 0->1
//   fall    - one-clock pulse when dout[i] goes 1->0
//   changed - OR of all rise/fall bits, same cycle as the pulses
module sync_filter #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILT_CNT    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned CW_RAW = $clog2(FILT_CNT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);

    logic [WIDTH-1:0]         sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]         sync;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_next;
    logic [WIDTH-1:0]         dout_next;
    logic [WIDTH-1:0]         rise_next;
    logic [WIDTH-1:0]         fall_next;

    // Synchronizer chain shifts every clock, independent of ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-channel filter: count consecutive differing samples; any matching
    // sample clears the count, so short glitches never reach dout.
    always_comb begin
        cnt_next  = cnt_q;
        dout_next = dout;
        rise_next = '0;
        fall_next = '0;
        if (ce) begin
            for (int unsigned ch = 0; ch < WIDTH; ch++) begin
                if (sync[ch] == dout[ch]) begin
                    cnt_next[ch] = '0;
                end else if (cnt_q[ch] == LAST) begin
                    cnt_next[ch]  = '0;
                    dout_next[ch] = sync[ch];
                    rise_next[ch] = sync[ch];
                    fall_next[ch] = ~sync[ch];
                end else begin
                    cnt_next[ch] = cnt_q[ch] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            dout    <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            cnt_q   <= cnt_next;
            dout    <= dout_next;
            rise    <= rise_next;
            fall    <= fall_next;
            changed <= |(rise_next | fall_next);
        end
    end

endmodule

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel input conditioner that replaces ad-hoc single-bit flip-flops on asynchronous inputs such as the UART RX line, CTS and external strobes. Each channel passes through a SYNC_STAGES-deep synchronizer chain, then a consecutive-sample glitch filter gated by a sample enable. The block outputs a clean level per channel plus single-cycle rise and fall pulses. It sits between the pads and the UART receiver/control FSMs.

## Interface
- WIDTH, 1: number of independent channels.
- SYNC_STAGES, 2: synchronizer flip-flops per channel; legal range ≥2.
- FILT_CNT, 4: consecutive differing samples required to change the filtered output; legal range ≥1.
- RESET_VAL, {WIDTH{1'b1}}: per-channel reset level for the synchronizer stages and dout. Defaults to UART idle-high.

- clk  input  1  rising-edge clock; all state changes on this edge.
- reset  input  1  synchronous, active-high; takes priority over all other inputs.
- ce  input  1  filter sample enable (e.g. 16x baud tick); has no effect on the synchronizer.
- din  input  WIDTH  asynchronous raw inputs.
- dout  output  WIDTH  filtered level, registered.
- rise  output  WIDTH  1-clk pulse when dout[i] changes 0→1.
- fall  output  WIDTH  1-clk pulse when dout[i] changes 1→0.
- changed  output  1  registered OR of rise|fall, asserted in the same cycle as the pulse.

## Operation
- Synchronizer: per channel, a shift chain s[0..SYNC_STAGES-1] clocked every clk regardless of ce. s[0] <= din[i]; sync[i] = s[SYNC_STAGES-1].
- Filter state: per channel, counter cnt[i] of width $clog2(FILT_CNT+1), minimum 1 bit.
- On a clk edge with ce=1 and no reset, per channel:
  - sync[i] == dout[i]: cnt <= 0. dout holds.
  - sync[i] != dout[i] and cnt < FILT_CNT-1: cnt <= cnt+1. dout holds.
  - sync[i] != dout[i] and cnt == FILT_CNT-1: dout <= sync[i], cnt <= 0. rise[i] or fall[i] <= 1 according to direction.
- ce=0: cnt and dout hold. The synchronizer still shifts.
- Pulse outputs: rise, fall and changed are 0 on every edge that does not update dout, so each pulse lasts exactly one clk. Back-to-back ce edges cannot produce consecutive pulses on one channel unless FILT_CNT=1.
- FILT_CNT=1: dout takes sync on every ce edge where they differ, with no filtering.
- Glitch rejection: any matching sample before the count completes clears cnt. A pulse shorter than FILT_CNT ce-samples never reaches dout.
- Channels are fully independent. Simultaneous updates on several channels are legal and set several rise/fall bits in the same cycle.
- Reset (synchronous, active-high):
  - all s stages <= RESET_VAL; dout <= RESET_VAL.
  - cnt <= 0; rise, fall, changed <= 0.
  - Reset asserted mid-count discards the partial count. After release, filtering restarts from cnt=0 against dout=RESET_VAL.

## Timing
- Reset values: dout=RESET_VAL, rise=0, fall=0, changed=0. These are visible in the cycle after the first reset edge.
- Latency with ce held high: din is stable at its new value before edge E1. dout, the pulse and changed all change on edge E(SYNC_STAGES+FILT_CNT).
  - Defaults (2,4): the change appears after the 6th edge.
- With a strided ce: dout changes on the FILT_CNT-th ce edge at which sync already shows the new value.
- din must be held for at least FILT_CNT consecutive ce samples, as seen at sync, to propagate.
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset 2 cycles with din=0, WIDTH=1, defaults -> dout=1, rise=fall=changed=0; dout stays 1 for the next 2 cycles after release.
- Latency: ce=1, din steps 1→0 before E1 -> dout=0 and fall=1 exactly after E6; fall=0 after E7; rise never asserts.
- Glitch: ce=1, din low for exactly 3 clk cycles, then high -> dout stays 1 and no pulses. Repeat with a 4-cycle low -> exactly one fall pulse, then one rise pulse 4 edges after the synchronized return to high.
- Strided ce: ce every 16th cycle, din steps 0→1 with dout=0 -> rise fires on the 4th ce edge after sync goes high. Counters hold between ticks.
- Multi-channel: WIDTH=4, FILT_CNT=2, RESET_VAL=4'b0000, din 0000→1010 -> rise=1010 and changed=1 on the same edge; fall=0000.
- Reset mid-count: din changes, then reset is asserted for 1 cycle after 2 of 4 samples -> no pulse. dout stays RESET_VAL until 4 fresh samples after release.
